// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the configuration chain writer.
// Provides the writer state enum, row geometry and default chain parameters.
package cfg_pkg;
    localparam int CFG_WORDS_PER_ROW = 3;
    localparam int CFG_CHAIN_LEN     = 4 * CFG_WORDS_PER_ROW;
    localparam int CFG_CLK_DIV       = 2;
    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } cfg_wr_state_t;
endpackage

// File: rtl/fp_pkg.sv
// fp: numeric word type shared by the configuration datapath.
// Provides fpType, the 16-bit word carried by the row configuration chain.
package fp;
    typedef logic [15:0] fpType;
endpackage

// File: rtl/config_if.sv
// config_if: one link of the row configuration shift chain.
// Signals: data_clk (chain shift clock), data_in (word presented to the chain).
// Modports: master drives the link, slave observes it.
interface config_if;
    logic      data_clk;
    fp::fpType data_in;
    modport master (output data_clk, output data_in);
    modport slave  (input data_clk, input data_in);
endinterface

// File: rtl/cfg_clk_gen.sv
// cfg_clk_gen: divided chain clock with rise/fall strobes.
// Ports: clk, reset_n (async active-low), en_i (run the divider),
//        data_clk_o (registered chain clock, low when disabled),
//        rise_stb_o / fall_stb_o (high in the cycle whose closing edge makes data_clk rise/fall).
module cfg_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    output logic data_clk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt_q;
    logic          data_clk_q;
    logic          wrap;
    assign wrap       = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_stb_o = wrap && !data_clk_q;
    assign fall_stb_o = wrap && data_clk_q;
    assign data_clk_o = data_clk_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt_q      <= '0;
            data_clk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q      <= '0;
            data_clk_q <= 1'b0;
        end else begin
            cnt_q      <= wrap ? '0 : cnt_q + 1'b1;
            data_clk_q <= data_clk_q ^ wrap;
        end
endmodule

// File: rtl/config_chain_writer.sv
// config_chain_writer: collects one frame of words and shifts it into the row configuration chain.
// Ports: clk, reset_n (async active-low), word_data/word_valid/word_ready (frame word stream),
//        cfg_out (chain master: data_clk, data_in), busy (shifting), done (frame complete pulse).
// Optional macro CFG_READBACK_EN adds cfg_ret (chain tail return), err (sticky mismatch) and
// err_count (saturating mismatch count), plus a second verify pass after every shift pass.
module config_chain_writer
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN = CFG_CHAIN_LEN,
    parameter int CLK_DIV   = CFG_CLK_DIV
) (
    input  logic      clk,
    input  logic      reset_n,
    input  fp::fpType word_data,
    input  logic      word_valid,
    output logic      word_ready,
    config_if.master  cfg_out,
    output logic      busy,
    output logic      done
`ifdef CFG_READBACK_EN
    ,
    config_if.slave   cfg_ret,
    output logic      err,
    output logic [15:0] err_count
`endif
);
    localparam int IW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHAIN_LEN - 1);
    cfg_wr_state_t state_q;
    logic [IW-1:0] wr_idx_q, k_q, k_d;
    fp::fpType     buf_q [CHAIN_LEN];
    fp::fpType     data_in_q;
    logic          word_ready_q, busy_q, done_q;
    logic          data_clk, rise_stb, fall_stb, accept, last_word;
    assign accept     = word_valid && word_ready_q;
    assign last_word  = wr_idx_q == LAST;
    assign k_d        = (k_q == LAST) ? '0 : k_q + 1'b1;
    assign word_ready = word_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_out.data_clk = data_clk;
    assign cfg_out.data_in  = data_in_q;
    // busy_q is high exactly in the shifting states, so it gates the divider
    cfg_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (busy_q),
        .data_clk_o (data_clk),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );
    always_ff @(posedge clk)
        if (accept) buf_q[wr_idx_q] <= word_data;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q      <= ST_FILL;
            wr_idx_q     <= '0;
            k_q          <= '0;
            data_in_q    <= '0;
            word_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_FILL: if (accept) begin
                    wr_idx_q <= last_word ? '0 : wr_idx_q + 1'b1;
                    if (last_word) begin
                        state_q      <= ST_SHIFT;
                        word_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        // a one-word frame has not reached the buffer yet
                        data_in_q    <= (wr_idx_q == '0) ? word_data : buf_q[0];
                    end
                end
                ST_DONE: begin
                    state_q      <= ST_FILL;
                    word_ready_q <= 1'b1;
                end
                default: if (fall_stb) begin
                    k_q       <= k_d;
                    data_in_q <= buf_q[k_d];
                    if (k_q == LAST) begin
`ifdef CFG_READBACK_EN
                        state_q <= (state_q == ST_SHIFT) ? ST_VERIFY : ST_DONE;
                        busy_q  <= state_q == ST_SHIFT;
                        done_q  <= state_q != ST_SHIFT;
`else
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end
                end
            endcase
        end
`ifdef CFG_READBACK_EN
    logic        err_q;
    logic [15:0] err_count_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    // the tail value is taken at the rising edge, i.e. as held through the last low-phase cycle
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else if (state_q == ST_VERIFY && rise_stb && cfg_ret.data_in != buf_q[k_q]) begin
            err_q       <= 1'b1;
            err_count_q <= err_count_q + 16'(err_count_q != 16'hFFFF);
        end
`endif
endmodule

// File: tb/tb_config_chain_writer.sv
// tb_config_chain_writer: directed bench for config_chain_writer with three divider/length variants.
module tb_config_chain_writer;
`ifdef CFG_READBACK_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int DIV [3] = '{2, 1, 3};
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] wv = '0;
    logic [2:0] wr, dn, bz;
    fp::fpType  wd [3] = '{default: '0};
    int         n_cmp = 0;
    int         n_bad = 0;
    config_if ifa ();
    config_if ifb ();
    config_if ifc ();
    always #5 clk = ~clk;

    fp::fpType a_ch [3];
    fp::fpType b_ch [12];
    fp::fpType c_ch [2];
    int        ra_n = 0, rb_n = 0, rc_n = 0, b_base = 0;
    logic      b_corrupt = 1'b0;
    always @(posedge ifa.data_clk) begin
        a_ch[0] <= ifa.data_in;
        for (int j = 1; j < 3; j++) a_ch[j] <= a_ch[j-1];
        ra_n <= ra_n + 1;
    end
    always @(posedge ifb.data_clk) begin
        b_ch[0] <= ifb.data_in;
        for (int j = 1; j < 12; j++) b_ch[j] <= b_ch[j-1];
        if (b_corrupt && rb_n - b_base == 11) b_ch[5] <= 16'hFFFF;
        rb_n <= rb_n + 1;
    end
    always @(posedge ifc.data_clk) begin
        c_ch[0] <= ifc.data_in;
        c_ch[1] <= c_ch[0];
        rc_n <= rc_n + 1;
    end

`ifdef CFG_READBACK_EN
    config_if rta ();
    config_if rtb ();
    config_if rtc ();
    logic [2:0] er;
    logic [15:0] ec [3];
    assign rta.data_clk = ifa.data_clk;
    assign rta.data_in  = a_ch[2];
    assign rtb.data_clk = ifb.data_clk;
    assign rtb.data_in  = b_ch[11];
    assign rtc.data_clk = ifc.data_clk;
    assign rtc.data_in  = c_ch[1];
`endif

    config_chain_writer #(.CHAIN_LEN(3), .CLK_DIV(2)) u_a (
        .clk(clk), .reset_n(reset_n), .word_data(wd[0]), .word_valid(wv[0]), .word_ready(wr[0]),
        .cfg_out(ifa), .busy(bz[0]), .done(dn[0])
`ifdef CFG_READBACK_EN
        , .cfg_ret(rta), .err(er[0]), .err_count(ec[0])
`endif
    );
    config_chain_writer #(.CHAIN_LEN(12), .CLK_DIV(1)) u_b (
        .clk(clk), .reset_n(reset_n), .word_data(wd[1]), .word_valid(wv[1]), .word_ready(wr[1]),
        .cfg_out(ifb), .busy(bz[1]), .done(dn[1])
`ifdef CFG_READBACK_EN
        , .cfg_ret(rtb), .err(er[1]), .err_count(ec[1])
`endif
    );
    config_chain_writer #(.CHAIN_LEN(2), .CLK_DIV(3)) u_c (
        .clk(clk), .reset_n(reset_n), .word_data(wd[2]), .word_valid(wv[2]), .word_ready(wr[2]),
        .cfg_out(ifc), .busy(bz[2]), .done(dn[2])
`ifdef CFG_READBACK_EN
        , .cfg_ret(rtc), .err(er[2]), .err_count(ec[2])
`endif
    );

    // phase-width and data-stability monitor for all three instances
    logic [2:0] dcv, prev_dc = '0, lo_ok = '0;
    fp::fpType  dinv [3];
    fp::fpType  prev_din [3] = '{default: '0};
    int run_len [3] = '{default: 0};
    int hi_runs [3] = '{default: 0};
    int bad_hi  [3] = '{default: 0};
    int bad_lo  [3] = '{default: 0};
    int bad_din [3] = '{default: 0};
    assign dcv = {ifc.data_clk, ifb.data_clk, ifa.data_clk};
    assign dinv[0] = ifa.data_in;
    assign dinv[1] = ifb.data_in;
    assign dinv[2] = ifc.data_in;
    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            if (!reset_n) begin
                prev_dc[i]  <= 1'b0;
                lo_ok[i]    <= 1'b0;
                run_len[i]  <= 0;
                prev_din[i] <= dinv[i];
            end else begin
                if (dcv[i] != prev_dc[i]) begin
                    run_len[i] <= 1;
                    lo_ok[i]   <= prev_dc[i] && bz[i];
                    if (prev_dc[i]) begin
                        hi_runs[i] <= hi_runs[i] + 1;
                        if (run_len[i] != DIV[i]) bad_hi[i] <= bad_hi[i] + 1;
                    end else if (lo_ok[i] && run_len[i] != DIV[i]) bad_lo[i] <= bad_lo[i] + 1;
                end else begin
                    run_len[i] <= run_len[i] + 1;
                    if (!bz[i]) lo_ok[i] <= 1'b0;
                end
                if (dcv[i] && dinv[i] != prev_din[i]) bad_din[i] <= bad_din[i] + 1;
                prev_dc[i]  <= dcv[i];
                prev_din[i] <= dinv[i];
            end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [15:0] w);
        int n = 0;
        wd[i] = w;
        wv[i] = 1'b1;
        do begin
            @(posedge clk);
            n++;
        end while (!wr[i] && n < 500);
        if (!wr[i]) chk($sformatf("push%0d_timeout", i), 0, 1);
        #1 wv[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int c = 0;
        while (!dn[i] && c < 500) begin
            @(negedge clk);
            c++;
        end
        if (!dn[i]) chk($sformatf("done%0d_timeout", i), 0, 1);
        @(negedge clk);
    endtask

    int first_hi, done_at, pulses, rdy_at, r;
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dclk", ifa.data_clk, 0);
        chk("rst_din", ifa.data_in, 0);
        chk("rst_busy", bz[0], 0);
        chk("rst_done", dn[0], 0);
        chk("rst_dclk_b", ifb.data_clk, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", wr[0], 1);

        r = ra_n;
        push(0, 16'h0011);
        push(0, 16'h0022);
        push(0, 16'h0033);
        first_hi = -1;
        done_at = -1;
        pulses = 0;
        for (int c = 0; c < 12 * PASSES + 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("shift_busy", bz[0], 1);
                chk("shift_ready", wr[0], 0);
            end
            if (ifa.data_clk && first_hi < 0) first_hi = c;
            if (dn[0]) begin
                pulses++;
                done_at = c;
            end
        end
        chk("first_rise", first_hi, 2);
        chk("done_pulses", pulses, 1);
        chk("done_at", done_at, 12 * PASSES);
        chk("row_rises", ra_n - r, 3 * PASSES);
        chk("row_address", a_ch[2], 16'h0011);
        chk("row_e_rev", a_ch[1], 16'h0022);
        chk("row_e_l", a_ch[0], 16'h0033);

        push(0, 16'h00A1);
        push(0, 16'h00A2);
        push(0, 16'h00A3);
        wd[0] = 16'h00B1;
        wv[0] = 1'b1;
        rdy_at = -1;
        for (int c = 0; c < 12 * PASSES + 10; c++) begin
            @(negedge clk);
            if (wr[0]) begin
                rdy_at = c;
                break;
            end
        end
        chk("bp_ready_at", rdy_at, 12 * PASSES + 1);
        @(posedge clk);
        #1 wv[0] = 1'b0;
        push(0, 16'h00B2);
        push(0, 16'h00B3);
        wait_done(0);
        chk("bp_address", a_ch[2], 16'h00B1);
        chk("bp_e_rev", a_ch[1], 16'h00B2);
        chk("bp_e_l", a_ch[0], 16'h00B3);

        r = rb_n;
        for (int j = 0; j < 12; j++) push(1, 16'(16'h0100 + j));
        wait_done(1);
        chk("b_rises", rb_n - r, 12 * PASSES);
        chk("b_deep", b_ch[11], 16'h0100);
        chk("b_mid", b_ch[6], 16'h0105);
        chk("b_head", b_ch[0], 16'h010B);
        r = rc_n;
        push(2, 16'h0C01);
        push(2, 16'h0C02);
        wait_done(2);
        chk("c_rises", rc_n - r, 2 * PASSES);
        chk("c_deep", c_ch[1], 16'h0C01);
        chk("c_head", c_ch[0], 16'h0C02);
        chk("c_hi_runs", hi_runs[2], 2 * PASSES);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hi_width%0d", i), bad_hi[i], 0);
            chk($sformatf("lo_width%0d", i), bad_lo[i], 0);
            chk($sformatf("din_stable%0d", i), bad_din[i], 0);
        end

        r = rb_n;
        for (int j = 0; j < 12; j++) push(1, 16'(16'h0200 + j));
        for (int c = 0; c < 200 && rb_n - r < 2; c++) @(negedge clk);
        chk("mid_dclk_high", ifb.data_clk, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_dclk_async", ifb.data_clk, 0);
        chk("mid_busy", bz[1], 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("mid_ready", wr[1], 1);
        r = rb_n;
        for (int j = 0; j < 12; j++) push(1, 16'(16'h0300 + j));
        wait_done(1);
        chk("mid_rises", rb_n - r, 12 * PASSES);
        chk("mid_deep", b_ch[11], 16'h0300);
        chk("mid_stage5", b_ch[5], 16'h0306);
        chk("mid_head", b_ch[0], 16'h030B);
        chk("mid_din_stable", bad_din[1], 0);

`ifdef CFG_READBACK_EN
        chk("rb_err_clean", er[1], 0);
        chk("rb_cnt_clean", ec[1], 0);
        b_base = rb_n;
        b_corrupt = 1'b1;
        for (int j = 0; j < 12; j++) push(1, 16'(16'h0400 + j));
        wait_done(1);
        chk("rb_err", er[1], 1);
        chk("rb_cnt", ec[1], 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/config_chain_writer.md
# config_chain_writer

Drives the row configuration shift chain from the controller side. The block collects one full frame of `fp::fpType` words over a valid/ready stream and shifts them into the chain through a `config_if` master. It generates the chain's `data_clk` from the system clock. It sits between the host configuration port and the first row's `cfg_in`. Each row stage holds three words: the first word shifted lands in `address`, the second in `E_rev`, the third in `E_l`.

## Interface
Parameters:
- `CHAIN_LEN`, default 12: words per frame (3 per row × 4 rows); must be ≥1.
- `CLK_DIV`, default 2: `clk` cycles per `data_clk` half-period; must be ≥1.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `reset_n`  in  1  reset; asynchronous assert, active-low.
- `word_data`  in  fp::fpType  frame word.
- `word_valid`  in  1  word offered.
- `word_ready`  out  1  word accepted when `word_valid && word_ready` at a `clk` rise.
- `cfg_out`  config_if.master  —  chain output; drives `data_clk` and `data_in`.
- `busy`  out  1  high while shifting.
- `done`  out  1  one-cycle pulse at frame completion.
- `cfg_ret`  config_if.slave  —  chain tail return; present only with `CFG_READBACK_EN`.
- `err`  out  1  sticky readback mismatch; present only with `CFG_READBACK_EN`.
- `err_count`  out  16  saturating mismatch count; present only with `CFG_READBACK_EN`.

## Operation
- States are FILL, SHIFT, VERIFY (macro only) and DONE.
- **FILL**
  - `word_ready` = 1.
  - Each accepted word goes to `buf[wr_idx]`, and `wr_idx` increments.
  - When the CHAIN_LEN-th word is accepted, the state goes to SHIFT on the next cycle and `wr_idx` clears.
- **SHIFT**
  - `word_ready` = 0 and `busy` = 1.
  - A shift index k runs 0..CHAIN_LEN-1, and `data_in` = `buf[k]`.
  - Each k has a low phase then a high phase:
    - `data_clk` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - `data_in` changes only in the cycle `data_clk` falls (or on SHIFT entry).
  - After the high phase of k = CHAIN_LEN-1, `data_clk` returns low and the state goes to VERIFY (if enabled) or DONE.
- **VERIFY**
  - Repeats the SHIFT sequence with identical words.
  - On each `data_clk` rise, the block compares `cfg_ret.data_in`, sampled in the last low-phase cycle, against `buf[k]`.
  - On a mismatch, `err` ← 1 and `err_count` increments, saturating at 0xFFFF.
  - The chain ends holding the same frame.
- **DONE**
  - `done` = 1 for one cycle, then the state returns to FILL.
  - The buffer is retained but gets overwritten.
- Words are shifted in arrival order, so the first word received ends deepest (last row, `address`).
- A valid word during SHIFT/VERIFY/DONE is held off by `word_ready` = 0; it is never dropped.
- Reset values: state FILL, `data_clk` 0, `data_in` 0, `word_ready` 1 after release, `busy` 0, `done` 0, `err` 0, `err_count` 0, all indices 0.
- Reset mid-frame: `data_clk` goes low immediately (asynchronous). Partial buffer and chain contents are discarded or undefined. The next frame starts from `wr_idx` 0.
- `err`/`err_count` clear only on reset.

## Timing
- Handshake latency is 1 cycle: the word is accepted at the edge.
- From the last accepted word to the first `data_clk` rise: 1 + CLK_DIV cycles.
- A SHIFT pass takes 2·CLK_DIV·CHAIN_LEN cycles; VERIFY adds the same again.
- `done` asserts on the cycle after the final falling `data_clk`. FILL (`word_ready` = 1) resumes on the cycle after `done`.
- `data_clk` is a registered output, glitch-free, with 50 % duty.
- `data_in` is stable for CLK_DIV cycles before and after every rising edge.

## Configuration
- `CFG_READBACK_EN` defined:
  - `cfg_ret`, `err` and `err_count` exist.
  - The VERIFY pass runs after every SHIFT pass.
- Undefined:
  - Those ports and the VERIFY state are absent.
  - SHIFT goes directly to DONE.

## Structure
- Shared package `cfg_pkg`:
  - state enum `cfg_wr_state_t`.
  - `CFG_WORDS_PER_ROW` = 3.
  - default `CFG_CHAIN_LEN` and `CFG_CLK_DIV`.
- `fp::fpType` comes from the existing `fp` package.
- Sub-module `cfg_clk_gen`:
  - phase counter producing `data_clk` plus single-cycle `rise_stb`/`fall_stb` strobes.
  - enabled by the FSM.

## Test plan
- **Reset:** hold `reset_n` = 0 → `data_clk` = 0, `data_in` = 0, `busy` = 0, `done` = 0; `word_ready` = 1 after release.
- **Single-row frame** (CHAIN_LEN = 3, CLK_DIV = 2): push 0x0011, 0x0022, 0x0033 →
  - exactly 3 `data_clk` rises, with `data_in` = 0x0011, 0x0022, 0x0033 at the rises.
  - a row model holds address = 0x0011, E_rev = 0x0022, E_l = 0x0033.
  - `done` pulses once, 12 cycles after the first shift cycle.
- **Backpressure:** keep `word_valid` = 1 with a new word during SHIFT → `word_ready` = 0 and nothing accepted until the cycle after `done`; that word becomes `buf[0]` of the next frame.
- **Divider:** CLK_DIV = 1 and CLK_DIV = 3 → high and low phases are each exactly CLK_DIV cycles; `data_in` never changes while `data_clk` = 1.
- **Reset mid-shift:** assert `reset_n` after 2 rises of a 12-word frame → `data_clk` = 0 asynchronously; a following full frame shifts 12 rises with correct data.
- **Readback** (`CFG_READBACK_EN`):
  - 12-stage loopback model → `err` = 0, `err_count` = 0.
  - Stage 5 forced to 0xFFFF → `err` = 1, `err_count` = 1.
